// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a wait-state memory port, latching the fetched word and trapping on bad opcodes or stalls.
module multicycle_control_fsm #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 0,
    parameter bit TRAP_HALT   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic [XLEN-1:0] ir,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            alu_src,
    output logic [1:0]      alu_op,
    output logic            illegal,
    output logic            bus_error,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    // The counter only has to reach MEM_TIMEOUT-1; the trap fires on that last stalled cycle.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt;
    logic [6:0]         opcode;
    logic               opcode_legal;
    logic               is_load;
    logic [1:0]         alu_op_dec;
    logic               alu_src_dec;
    logic               mem_wait;
    logic               timeout_hit;

    assign opcode      = ir[6:0];
    assign state       = state_q;
    assign mem_wait    = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        opcode_legal = 1'b0;
        is_load      = 1'b0;
        alu_op_dec   = ALU_ADD;
        alu_src_dec  = 1'b0;
        case (opcode)
            OP_R: begin
                opcode_legal = 1'b1;
                alu_op_dec   = ALU_FUNCT;
            end
            OP_IMM: begin
                opcode_legal = 1'b1;
                alu_op_dec   = ALU_FUNCT;
                alu_src_dec  = 1'b1;
            end
            OP_LOAD: begin
                opcode_legal = 1'b1;
                is_load      = 1'b1;
                alu_src_dec  = 1'b1;
            end
            OP_STORE: begin
                opcode_legal = 1'b1;
                alu_src_dec  = 1'b1;
            end
            OP_BRANCH: begin
                opcode_legal = 1'b1;
                alu_op_dec   = ALU_SUB;
            end
            OP_JAL, OP_JALR, OP_AUIPC: begin
                opcode_legal = 1'b1;
                alu_src_dec  = 1'b1;
            end
            OP_LUI: begin
                opcode_legal = 1'b1;
                alu_op_dec   = ALU_PASSB;
                alu_src_dec  = 1'b1;
            end
            default: begin
                opcode_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                end
            end
            DECODE: begin
                state_d = opcode_legal ? EXEC : TRAP;
            end
            EXEC: begin
                alu_op  = alu_op_dec;
                alu_src = alu_src_dec;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEM;
                    // Branches retire here: taken or not, the PC moves and no WB is spent.
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = alu_zero ? PC_BRANCH : PC_PLUS4;
                        state_d  = FETCH;
                    end
                    OP_R, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = WB;
                    default: state_d = IDLE;
                endcase
            end
            MEM: begin
                iord      = 1'b1;
                alu_op    = alu_op_dec;
                alu_src   = alu_src_dec;
                mem_read  = is_load;
                mem_write = !is_load;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                alu_op     = alu_op_dec;
                alu_src    = alu_src_dec;
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                pc_write   = 1'b1;
                if (opcode == OP_JAL) begin
                    pc_src = PC_JAL;
                end else if (opcode == OP_JALR) begin
                    pc_src = PC_JALR;
                end
                state_d = FETCH;
            end
            TRAP: begin
                if (!TRAP_HALT) begin
                    pc_write = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Any state change restarts the wait count, so each FETCH/MEM access is timed on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir        <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                ir <= mem_rdata;
            end
            if ((state_q == DECODE) && (state_d == TRAP)) begin
                illegal <= 1'b1;
            end
            if (((state_q == FETCH) || (state_q == MEM)) && (state_d == TRAP)) begin
                bus_error <= 1'b1;
            end
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each driven cycle queues its expected outputs,
// which a negedge monitor pops and compares. Instance a halts on traps, instance b skips them.
module tb_multicycle_control_fsm;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [31:0] I_ADDI  = 32'h00508093;
    localparam logic [31:0] I_LW    = 32'h00408183;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_JAL   = 32'h001000EF;
    localparam logic [31:0] I_JALR  = 32'h00108067;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_ALL1  = 32'hFFFFFFFF;
    localparam logic [31:0] I_BADLO = 32'h00508090;

    typedef struct packed {
        logic [2:0] st;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       m2r;
        logic       asrc;
        logic [1:0] aop;
        logic       ill;
        logic       berr;
    } outv_t;

    localparam outv_t CARE_ALL    = 17'b111_1_1_11_1_1_1_1_1_1_11_1_1;
    localparam outv_t CARE_NOASRC = 17'b111_1_1_11_1_1_1_1_1_0_11_1_1;
    localparam outv_t CARE_NOALU  = 17'b111_1_1_11_1_1_1_1_1_0_00_1_1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    bit          sel = 1'b0;

    logic [31:0] ir_a, ir_b;
    logic        ir_write_a, pc_write_a, iord_a, mem_read_a, mem_write_a, reg_write_a;
    logic        mem_to_reg_a, alu_src_a, illegal_a, bus_error_a;
    logic [1:0]  pc_src_a, alu_op_a;
    logic [2:0]  state_a;
    logic        ir_write_b, pc_write_b, iord_b, mem_read_b, mem_write_b, reg_write_b;
    logic        mem_to_reg_b, alu_src_b, illegal_b, bus_error_b;
    logic [1:0]  pc_src_b, alu_op_b;
    logic [2:0]  state_b;

    outv_t       obs_a, obs_b;
    logic [31:0] ir_obs;

    int          checks = 0;
    int          failures = 0;
    string       tagq[$];
    outv_t       expq[$];
    outv_t       careq[$];
    string       mon_tag;
    outv_t       mon_exp, mon_care, mon_obs;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.XLEN(32), .MEM_TIMEOUT(4), .TRAP_HALT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .ir(ir_a), .ir_write(ir_write_a), .pc_write(pc_write_a),
        .pc_src(pc_src_a), .iord(iord_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .reg_write(reg_write_a), .mem_to_reg(mem_to_reg_a), .alu_src(alu_src_a),
        .alu_op(alu_op_a), .illegal(illegal_a), .bus_error(bus_error_a), .state(state_a)
    );

    multicycle_control_fsm #(.XLEN(32), .MEM_TIMEOUT(0), .TRAP_HALT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .ir(ir_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
        .pc_src(pc_src_b), .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .reg_write(reg_write_b), .mem_to_reg(mem_to_reg_b), .alu_src(alu_src_b),
        .alu_op(alu_op_b), .illegal(illegal_b), .bus_error(bus_error_b), .state(state_b)
    );

    assign obs_a = {state_a, ir_write_a, pc_write_a, pc_src_a, iord_a, mem_read_a, mem_write_a,
                    reg_write_a, mem_to_reg_a, alu_src_a, alu_op_a, illegal_a, bus_error_a};
    assign obs_b = {state_b, ir_write_b, pc_write_b, pc_src_b, iord_b, mem_read_b, mem_write_b,
                    reg_write_b, mem_to_reg_b, alu_src_b, alu_op_b, illegal_b, bus_error_b};
    assign ir_obs = sel ? ir_b : ir_a;

    function automatic outv_t ov(input logic [2:0] st, input logic irw, input logic pcw,
                                 input logic [1:0] pcs, input logic iord, input logic mr,
                                 input logic mw, input logic rw, input logic m2r,
                                 input logic asrc, input logic [1:0] aop, input logic ill,
                                 input logic berr);
        return {st, irw, pcw, pcs, iord, mr, mw, rw, m2r, asrc, aop, ill, berr};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] rdata, input logic ready,
                                 input logic zero, input outv_t exp, input outv_t care);
        mem_rdata = rdata;
        mem_ready = ready;
        alu_zero  = zero;
        tagq.push_back(tag);
        expq.push_back(exp);
        careq.push_back(care);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_tag  = tagq.pop_front();
            mon_exp  = expq.pop_front();
            mon_care = careq.pop_front();
            mon_obs  = sel ? obs_b : obs_a;
            checkOutput(mon_tag, 32'(mon_obs & mon_care), 32'(mon_exp & mon_care));
        end
    end

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        applyStimulus(tag, '0, 1'b0, 1'b0, ov(S_IDLE, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), CARE_ALL);
        checkOutput({tag, "_ir"}, ir_obs, 32'h0);
        rst_n = 1'b1;
        applyStimulus({tag, "_idle"}, '0, 1'b1, 1'b0, ov(S_IDLE, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), CARE_ALL);
    endtask

    task automatic runFetch(input string tag, input logic [31:0] word, input logic ill, input logic berr);
        applyStimulus({tag, "_fetch"}, word, 1'b1, 1'b0, ov(S_FETCH, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, ill, berr), CARE_ALL);
        checkOutput({tag, "_ir"}, ir_obs, word);
        applyStimulus({tag, "_decode"}, '0, 1'b1, 1'b0, ov(S_DECODE, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ill, berr), CARE_ALL);
    endtask

    initial begin
        @(posedge clk);
        #1;

        doReset("rst0");

        runFetch("addi", I_ADDI, 0, 0);
        applyStimulus("addi_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0), CARE_ALL);
        applyStimulus("addi_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b10, 0, 0), CARE_NOASRC);

        runFetch("lw", I_LW, 0, 0);
        applyStimulus("lw_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), CARE_ALL);
        applyStimulus("lw_mem_w1", '0, 0, 0, ov(S_MEM, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        applyStimulus("lw_mem_w2", '0, 0, 0, ov(S_MEM, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        applyStimulus("lw_mem_rdy", 32'h00001234, 1, 0, ov(S_MEM, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        applyStimulus("lw_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0), CARE_NOALU);

        runFetch("sw", I_SW, 0, 0);
        applyStimulus("sw_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), CARE_ALL);
        applyStimulus("sw_mem_w1", '0, 0, 0, ov(S_MEM, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        applyStimulus("sw_mem_rdy", '0, 1, 0, ov(S_MEM, 0, 1, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0), CARE_NOALU);

        runFetch("beq_t", I_BEQ, 0, 0);
        applyStimulus("beq_t_exec", '0, 1, 1, ov(S_EXEC, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0), CARE_ALL);
        runFetch("beq_n", I_BEQ, 0, 0);
        applyStimulus("beq_n_exec", '0, 1, 0, ov(S_EXEC, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0), CARE_ALL);

        runFetch("jal", I_JAL, 0, 0);
        applyStimulus("jal_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOASRC);
        applyStimulus("jal_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b10, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        runFetch("jalr", I_JALR, 0, 0);
        applyStimulus("jalr_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOASRC);
        applyStimulus("jalr_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b11, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0), CARE_NOALU);

        runFetch("lui", I_LUI, 0, 0);
        applyStimulus("lui_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0), CARE_ALL);
        applyStimulus("lui_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        runFetch("add", I_ADD, 0, 0);
        applyStimulus("add_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0), CARE_ALL);
        applyStimulus("add_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        runFetch("auipc", I_AUIPC, 0, 0);
        applyStimulus("auipc_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOASRC);
        applyStimulus("auipc_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0), CARE_NOALU);

        runFetch("ill", I_ALL1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("ill_trap_hold", $urandom, 1'(i % 2), 1'(i % 3 == 0),
                          ov(S_TRAP, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0), CARE_ALL);
        end
        checkOutput("ill_ir_kept", ir_obs, I_ALL1);

        doReset("rst1");
        runFetch("badlo", I_BADLO, 0, 0);
        applyStimulus("badlo_trap", '0, 1, 0, ov(S_TRAP, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0), CARE_ALL);

        doReset("rst2");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("to_edge_wait", '0, 0, 0, ov(S_FETCH, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), CARE_ALL);
        end
        runFetch("to_edge", I_ADDI, 0, 0);
        applyStimulus("to_edge_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0), CARE_ALL);
        applyStimulus("to_edge_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b10, 0, 0), CARE_NOASRC);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("to_fetch_wait", '0, 0, 0, ov(S_FETCH, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), CARE_ALL);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("to_trap", '0, 1, 0, ov(S_TRAP, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), CARE_ALL);
        end

        doReset("rst3");
        runFetch("mid", I_LW, 0, 0);
        applyStimulus("mid_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), CARE_ALL);
        applyStimulus("mid_mem_w1", '0, 0, 0, ov(S_MEM, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0), CARE_NOALU);
        doReset("rst_mid_mem");

        sel = 1'b1;
        doReset("b_rst");
        runFetch("b_ill", I_ALL1, 0, 0);
        applyStimulus("b_trap_skip", '0, 1, 0, ov(S_TRAP, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0), CARE_ALL);
        runFetch("b_refetch", I_ADDI, 1, 0);
        applyStimulus("b_exec", '0, 1, 0, ov(S_EXEC, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0), CARE_ALL);
        applyStimulus("b_wb", '0, 1, 0, ov(S_WB, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b10, 1, 0), CARE_NOASRC);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("b_no_timeout", '0, 0, 0, ov(S_FETCH, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0), CARE_ALL);
        end
        runFetch("b_late", I_ADD, 1, 0);

        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
